// File: rtl/crossbar_in_arbiter_if.sv
// Requester-side and SRAM-side bundle of the crossbar input arbiter.
// The master is the requester/SRAM environment, the slave is the arbiter.
interface crossbar_in_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int N_BANK = 4,
  parameter int ADDR_W = 16
);
  localparam int IN_W = ADDR_W - $clog2(N_BANK);

  logic [N_REQ-1:0]         i_req;
  logic [N_REQ-1:0]         i_wren;
  logic [N_REQ*ADDR_W-1:0]  i_addr;
  logic [N_REQ*32-1:0]      i_wdata;
  logic [N_REQ*4-1:0]       i_wstrb;
  logic [N_REQ-1:0]         o_gnt;

  logic [N_BANK-1:0]        o_ram_en;
  logic [N_BANK-1:0]        o_ram_wren;
  logic [N_BANK*IN_W-1:0]   o_ram_addr;
  logic [N_BANK*32-1:0]     o_ram_wdata;
  logic [N_BANK*4-1:0]      o_ram_wstrb;
  logic [N_BANK*N_REQ-1:0]  o_peID;

  modport master (
    output i_req, i_wren, i_addr, i_wdata, i_wstrb,
    input  o_gnt, o_ram_en, o_ram_wren, o_ram_addr, o_ram_wdata, o_ram_wstrb, o_peID
  );

  modport slave (
    input  i_req, i_wren, i_addr, i_wdata, i_wstrb,
    output o_gnt, o_ram_en, o_ram_wren, o_ram_addr, o_ram_wdata, o_ram_wstrb, o_peID
  );
endinterface

// File: rtl/crossbar_in_arbiter.sv
// Per-bank round-robin arbiter with aging in front of the banked SRAM.
// Grant is combinational in the request cycle; the SRAM command is registered one cycle later.
module crossbar_in_arbiter #(
  parameter int N_REQ   = 4,
  parameter int N_BANK  = 4,
  parameter int ADDR_W  = 16,
  parameter int AGE_MAX = 7
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_conf_sel,
  crossbar_in_arbiter_if.slave bus
);
  localparam int BANK_BITS = $clog2(N_BANK);
  localparam int IN_W      = ADDR_W - BANK_BITS;
  localparam int RR_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int AGE_W     = 3;
  localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(AGE_MAX);

  logic [RR_W-1:0]   rr [N_BANK];
  logic [AGE_W-1:0]  w  [N_REQ];

  logic [N_REQ-1:0]  active;
  logic [N_REQ-1:0]  gnt;
  logic [N_BANK-1:0] win_vld;
  logic [RR_W-1:0]   win_idx [N_BANK];

  logic              sel_wren  [N_BANK];
  logic [IN_W-1:0]   sel_addr  [N_BANK];
  logic [31:0]       sel_wdata [N_BANK];
  logic [3:0]        sel_wstrb [N_BANK];
  logic [N_REQ-1:0]  sel_peid  [N_BANK];

  logic [N_BANK-1:0]       ram_en;
  logic [N_BANK-1:0]       ram_wren;
  logic [N_BANK*IN_W-1:0]  ram_addr;
  logic [N_BANK*32-1:0]    ram_wdata;
  logic [N_BANK*4-1:0]     ram_wstrb;
  logic [N_BANK*N_REQ-1:0] ram_peid;

  // In configuration mode only the highest-index requester is visible.
  always_comb begin
    for (int r = 0; r < N_REQ; r++) begin
      active[r] = bus.i_req[r] & (~i_conf_sel | (r == N_REQ - 1));
    end
  end

  always_comb begin
    logic [N_REQ-1:0] cont;
    logic [N_REQ-1:0] urg;
    logic [N_REQ-1:0] cand;
    logic [RR_W:0]    sum;
    logic [RR_W-1:0]  idx;
    gnt     = '0;
    win_vld = '0;
    for (int b = 0; b < N_BANK; b++) begin
      win_idx[b] = '0;
      cont       = '0;
      urg        = '0;
      for (int r = 0; r < N_REQ; r++) begin
        cont[r] = active[r] && (bus.i_addr[r*ADDR_W +: BANK_BITS] == BANK_BITS'(b));
        urg[r]  = cont[r] && (w[r] == AGE_SAT);
      end
      cand = (|urg) ? urg : cont;
      // Scan from the round-robin pointer, wrapping at N_REQ.
      for (int k = 0; k < N_REQ; k++) begin
        sum = {1'b0, rr[b]} + (RR_W+1)'(k);
        if (sum >= (RR_W+1)'(N_REQ)) sum = sum - (RR_W+1)'(N_REQ);
        idx = sum[RR_W-1:0];
        if (!win_vld[b] && cand[idx]) begin
          win_vld[b] = 1'b1;
          win_idx[b] = idx;
        end
      end
      if (win_vld[b]) gnt[win_idx[b]] = 1'b1;
    end
  end

  assign bus.o_gnt = gnt & {N_REQ{i_rst_n}};

  always_comb begin
    for (int b = 0; b < N_BANK; b++) begin
      sel_wren[b]  = 1'b0;
      sel_addr[b]  = '0;
      sel_wdata[b] = '0;
      sel_wstrb[b] = '0;
      sel_peid[b]  = '0;
      for (int r = 0; r < N_REQ; r++) begin
        if (win_vld[b] && (win_idx[b] == RR_W'(r))) begin
          sel_wren[b]  = bus.i_wren[r];
          sel_addr[b]  = bus.i_addr[r*ADDR_W + BANK_BITS +: IN_W];
          sel_wdata[b] = bus.i_wdata[r*32 +: 32];
          sel_wstrb[b] = bus.i_wstrb[r*4 +: 4];
          sel_peid[b]  = bus.i_wren[r] ? '0 : N_REQ'(1 << r);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int b = 0; b < N_BANK; b++) rr[b] <= '0;
      for (int r = 0; r < N_REQ; r++)  w[r]  <= '0;
    end else begin
      for (int b = 0; b < N_BANK; b++) begin
        if (win_vld[b]) rr[b] <= (win_idx[b] == RR_W'(N_REQ - 1)) ? '0 : win_idx[b] + 1'b1;
      end
      for (int r = 0; r < N_REQ; r++) begin
        if (gnt[r] || !active[r]) w[r] <= '0;
        else if (w[r] != AGE_SAT)  w[r] <= w[r] + 1'b1;
      end
    end
  end

  // Data fields hold when the bank is idle; only en and peID drop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ram_en    <= '0;
      ram_wren  <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_wstrb <= '0;
      ram_peid  <= '0;
    end else begin
      for (int b = 0; b < N_BANK; b++) begin
        ram_en[b]                  <= win_vld[b];
        ram_peid[b*N_REQ +: N_REQ] <= sel_peid[b];
        if (win_vld[b]) begin
          ram_wren[b]              <= sel_wren[b];
          ram_addr[b*IN_W +: IN_W] <= sel_addr[b];
          ram_wdata[b*32 +: 32]    <= sel_wdata[b];
          ram_wstrb[b*4 +: 4]      <= sel_wstrb[b];
        end
      end
    end
  end

  assign bus.o_ram_en    = ram_en;
  assign bus.o_ram_wren  = ram_wren;
  assign bus.o_ram_addr  = ram_addr;
  assign bus.o_ram_wdata = ram_wdata;
  assign bus.o_ram_wstrb = ram_wstrb;
  assign bus.o_peID      = ram_peid;
endmodule
